ordered_fwd_arb: RTL and testbench
==================================

Name: ordered_fwd_arb

Overview:
- Next-generation forwarder-side arbiter for the N-core packet filter array.
- Sits between the single forwarder interface and N packetfilter_core forwarder ports.
- Adds a run-time selectable mode: round-robin fairness, or strict in-order forwarding.
- In-order mode uses a ticket FIFO fed by the snoop arbiter's grant stream, so accepted packets leave in arrival order; rejected packets are skipped. Also adds packet/drop counters and overflow detection.

Parameters:
- N, 4, number of cores (2..64).
- TAG_SZ, CLOG2(N), core index width.
- PACKMEM_ADDR_WIDTH, 8, forwarder word address width.
- PACKMEM_DATA_WIDTH, 64, forwarder data width.
- PLEN_WIDTH, 32, byte length width.
- SEQ_DEPTH, 16, ticket FIFO depth; power of 2, >= N.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock (clk); reset rst is asynchronous and active-low.
- ordered  in  1  mode: 1 = in-order, 0 = round-robin. Sampled only in IDLE.
- sn_grant_vld  in  1  snoop arbiter handed a packet to core sn_grant_tag.
- sn_grant_tag  in  TAG_SZ  core index of that grant.
- core_rej  in  N  per-core one-cycle pulse: packet rejected by the filter.
- addr  in  PACKMEM_ADDR_WIDTH  forwarder read address.
- rd_en  in  1  forwarder read enable.
- rd_data  out  PACKMEM_DATA_WIDTH  muxed read data.
- rd_data_vld  out  1  muxed read-data valid.
- byte_len  out  PLEN_WIDTH  length of the selected packet.
- done  in  1  forwarder finished with the packet.
- rdy  out  1  a packet is offered.
- ack  in  1  forwarder accepts the offer.
- fwd_addr  out  PACKMEM_ADDR_WIDTH  broadcast address to cores.
- fwd_rd_en  out  N  one-hot read enable.
- fwd_rd_data  in  N*PACKMEM_DATA_WIDTH  core read data, core i at slice i.
- fwd_rd_data_vld  in  N  core read-data valid.
- fwd_byte_len  in  N*PLEN_WIDTH  core packet lengths.
- fwd_done  out  N  one-hot done pulse.
- rdy_for_fwd  in  N  core has an accepted packet.
- rdy_for_fwd_ack  out  N  one-hot ack pulse.
- pkt_cnt  out  CNT_WIDTH  packets forwarded.
- drop_cnt  out  CNT_WIDTH  tickets skipped because the packet was rejected.
- seq_ovf  out  1  sticky: a grant arrived while the FIFO was full.

Behaviour:
- Reset (async assert, sync deassert expected externally):
  - State IDLE, FIFO empty, sel=0, rr_ptr=0, rej_pend=0.
  - Counters 0, seq_ovf=0.
  - All outputs 0 (rd_data 0).
- States:
  - IDLE -> OFFER when a candidate exists; sel is registered on that transition.
  - OFFER: rdy=1, byte_len=fwd_byte_len[sel]. On ack: rdy_for_fwd_ack[sel] pulses in the same cycle (combinational) -> BUSY.
  - BUSY: fwd_addr=addr; fwd_rd_en[sel]=rd_en; rd_data/rd_data_vld muxed from sel combinationally, adding zero latency. On done: fwd_done[sel] pulses in the same cycle, pkt_cnt+1, in-order mode pops the FIFO, rr_ptr<=sel+1 mod N -> IDLE.
- Round-robin candidate: first i at or after rr_ptr, wrapping, with rdy_for_fwd[i]=1.
- In-order candidate:
  - Head tag h with rdy_for_fwd[h]=1 is the candidate.
  - If rej_pend[h]=1 (or core_rej[h] this cycle): pop, clear rej_pend[h], drop_cnt+1, stay IDLE. At most one skip per cycle.
  - FIFO empty or head core not ready: wait.
- core_rej[i] sets rej_pend[i], except in the same cycle that a skip clears it.
- FIFO:
  - Push on sn_grant_vld when not full. Full: discard, seq_ovf<=1. Simultaneous push and pop when full is allowed (not overflow).
  - Pointers are TAG-agnostic, width CLOG2(SEQ_DEPTH)+1, wrap naturally.
- ordered changes are ignored outside IDLE. Switching to 0 leaves FIFO contents intact; switching back resumes from the head.
- done or ack outside its state: ignored. Counters wrap at 2^CNT_WIDTH.

Decomposition:
- Shared package/header: CLOG2 macro, state encodings (IDLE=0, OFFER=1, BUSY=2).
- One natural sub-module: seq_fifo (SEQ_DEPTH x TAG_SZ, registered count, full/empty, same-cycle push/pop).
- Round-robin search and muxes stay inline.

Test Plan:
- Round-robin (ordered=0, N=4): cores 1 and 3 ready, rr_ptr=2 -> core 3 offered first, then core 1. pkt_cnt=2.
- In-order: grants tags 2,0,1; core 0 ready first -> no rdy until core 2 ready. Forward order 2,0,1.
- In-order skip: grants 1,3; core_rej[1] pulses; core 3 ready -> one cycle skip, drop_cnt=1, core 3 forwarded, pkt_cnt=1.
- Data path: BUSY on sel=2, rd_en=1, addr=5 -> fwd_rd_en=4'b0100, fwd_addr=5. rd_data equals core 2 slice the same cycle; byte_len=fwd_byte_len[2] in OFFER.
- Overflow (SEQ_DEPTH=4): 5 grants without pops -> seq_ovf=1, FIFO holds first 4. Push+pop when full -> no overflow.
- Reset mid-BUSY: rst low -> rdy, fwd_rd_en, fwd_done, rdy_for_fwd_ack, counters all 0 immediately (asynchronously); FIFO empty after release.

Source files
------------

// File: rtl/ordered_fwd_arb_pkg.sv
// rtl/ordered_fwd_arb_pkg.sv - shared state encodings and width helper for the forwarder arbiter
package ordered_fwd_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ordered_fwd_arb_seq.sv
// rtl/ordered_fwd_arb_seq.sv - grant ticket FIFO (seq_fifo) with registered count and same-cycle push/pop
module seq_fifo
  import ordered_fwd_arb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + PTR_ONE;
    if (do_pop && !do_push) cnt_d = cnt_q - PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ordered_fwd_arb.sv
// rtl/ordered_fwd_arb.sv - forwarder-side arbiter with round-robin or strict in-order core selection
module ordered_fwd_arb
  import ordered_fwd_arb_pkg::*;
#(
  parameter int N                  = 4,
  parameter int TAG_SZ             = clog2(N),
  parameter int PACKMEM_ADDR_WIDTH = 8,
  parameter int PACKMEM_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH         = 32,
  parameter int SEQ_DEPTH          = 16,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ordered,
  input  logic                            sn_grant_vld,
  input  logic [TAG_SZ-1:0]               sn_grant_tag,
  input  logic [N-1:0]                    core_rej,
  input  logic [PACKMEM_ADDR_WIDTH-1:0]   addr,
  input  logic                            rd_en,
  output logic [PACKMEM_DATA_WIDTH-1:0]   rd_data,
  output logic                            rd_data_vld,
  output logic [PLEN_WIDTH-1:0]           byte_len,
  input  logic                            done,
  output logic                            rdy,
  input  logic                            ack,
  output logic [PACKMEM_ADDR_WIDTH-1:0]   fwd_addr,
  output logic [N-1:0]                    fwd_rd_en,
  input  logic [N*PACKMEM_DATA_WIDTH-1:0] fwd_rd_data,
  input  logic [N-1:0]                    fwd_rd_data_vld,
  input  logic [N*PLEN_WIDTH-1:0]         fwd_byte_len,
  output logic [N-1:0]                    fwd_done,
  input  logic [N-1:0]                    rdy_for_fwd,
  output logic [N-1:0]                    rdy_for_fwd_ack,
  output logic [CNT_WIDTH-1:0]            pkt_cnt,
  output logic [CNT_WIDTH-1:0]            drop_cnt,
  output logic                            seq_ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [TAG_SZ-1:0]    TAG_ONE  = TAG_SZ'(1);
  localparam logic [TAG_SZ-1:0]    TAG_LAST = TAG_SZ'(N - 1);

  logic [1:0]           state_q, state_d;
  logic [TAG_SZ-1:0]    sel_q, sel_d, rr_ptr_q, rr_ptr_d;
  logic [N-1:0]         rej_pend_q, rej_pend_d;
  logic                 mode_q, mode_d, seq_ovf_q, seq_ovf_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

  logic [TAG_SZ-1:0]    head, cand, rr_idx;
  logic                 fifo_full, fifo_empty, fifo_pop, rr_found;

  seq_fifo #(.DEPTH(SEQ_DEPTH), .W(TAG_SZ)) u_seq (
    .clk   (clk),
    .rst_n (rst),
    .push  (sn_grant_vld),
    .pop   (fifo_pop),
    .din   (sn_grant_tag),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign seq_ovf  = seq_ovf_q;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = TAG_SZ'((int'(rr_ptr_q) + k) % N);
      if (!rr_found && rdy_for_fwd[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    mode_d     = mode_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    rej_pend_d = rej_pend_q | core_rej;
    fifo_pop   = 1'b0;
    rdy             = 1'b0;
    byte_len        = '0;
    rdy_for_fwd_ack = '0;
    fwd_addr        = '0;
    fwd_rd_en       = '0;
    rd_data         = '0;
    rd_data_vld     = 1'b0;
    fwd_done        = '0;

    case (state_q)
      ST_IDLE: begin
        mode_d = ordered;
        if (ordered) begin
          // A rejected head ticket is retired without waiting for its core to become ready.
          if (!fifo_empty) begin
            if (rej_pend_q[head] || core_rej[head]) begin
              fifo_pop         = 1'b1;
              rej_pend_d[head] = 1'b0;
              drop_cnt_d       = drop_cnt_q + CNT_ONE;
            end else if (rdy_for_fwd[head]) begin
              sel_d   = head;
              state_d = ST_OFFER;
            end
          end
        end else if (rr_found) begin
          sel_d   = rr_idx;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        rdy      = 1'b1;
        byte_len = fwd_byte_len[int'(sel_q)*PLEN_WIDTH +: PLEN_WIDTH];
        if (ack) begin
          rdy_for_fwd_ack[sel_q] = 1'b1;
          state_d                = ST_BUSY;
        end
      end
      ST_BUSY: begin
        byte_len         = fwd_byte_len[int'(sel_q)*PLEN_WIDTH +: PLEN_WIDTH];
        fwd_addr         = addr;
        fwd_rd_en[sel_q] = rd_en;
        rd_data          = fwd_rd_data[int'(sel_q)*PACKMEM_DATA_WIDTH +: PACKMEM_DATA_WIDTH];
        rd_data_vld      = fwd_rd_data_vld[sel_q];
        if (done) begin
          fwd_done[sel_q] = 1'b1;
          pkt_cnt_d       = pkt_cnt_q + CNT_ONE;
          fifo_pop        = mode_q;
          rr_ptr_d        = (sel_q == TAG_LAST) ? '0 : sel_q + TAG_ONE;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    seq_ovf_d = seq_ovf_q | (sn_grant_vld & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      rej_pend_q <= '0;
      mode_q     <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      seq_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      rej_pend_q <= rej_pend_d;
      mode_q     <= mode_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      seq_ovf_q  <= seq_ovf_d;
    end
  end

endmodule

// File: tb/tb_ordered_fwd_arb.sv
// tb/tb_ordered_fwd_arb.sv - scoreboard bench for ordered_fwd_arb (N=4, SEQ_DEPTH=4)
module tb_ordered_fwd_arb;

  logic          clk, rst, ordered, sn_grant_vld, rd_en, done, ack;
  logic [1:0]    sn_grant_tag;
  logic [3:0]    core_rej, rdy_for_fwd, fwd_rd_data_vld;
  logic [7:0]    addr, fwd_addr;
  logic [63:0]   rd_data;
  logic          rd_data_vld, rdy, seq_ovf;
  logic [31:0]   byte_len, pkt_cnt, drop_cnt;
  logic [3:0]    fwd_rd_en, fwd_done, rdy_for_fwd_ack;
  logic [255:0]  fwd_rd_data;
  logic [127:0]  fwd_byte_len;

  int errs = 0;
  int checks = 0;
  int exp_q[$];

  ordered_fwd_arb #(.N(4), .SEQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ordered(ordered),
    .sn_grant_vld(sn_grant_vld), .sn_grant_tag(sn_grant_tag), .core_rej(core_rej),
    .addr(addr), .rd_en(rd_en), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .byte_len(byte_len), .done(done), .rdy(rdy), .ack(ack),
    .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en), .fwd_rd_data(fwd_rd_data),
    .fwd_rd_data_vld(fwd_rd_data_vld), .fwd_byte_len(fwd_byte_len),
    .fwd_done(fwd_done), .rdy_for_fwd(rdy_for_fwd), .rdy_for_fwd_ack(rdy_for_fwd_ack),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .seq_ovf(seq_ovf)
  );

  for (genvar g = 0; g < 4; g++) begin : g_core
    assign fwd_rd_data[g*64 +: 64]  = 64'hC0DE_0000_0000_0000 + 64'(g*16 + 3);
    assign fwd_byte_len[g*32 +: 32] = 32'(100 + g);
  end
  assign fwd_rd_data_vld = 4'b0101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic [1:0] tag);
    sn_grant_vld = 1'b1;
    sn_grant_tag = tag;
    tick();
    sn_grant_vld = 1'b0;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("offer_seen", rdy, 1);
  endtask

  task automatic fwd_pkt();
    int e;
    logic [3:0] oh, vp;
    wait_rdy();
    if (rdy !== 1'b1) return;
    if (exp_q.size() == 0) begin
      chk("sb_size", exp_q.size(), 1);
      return;
    end
    e  = exp_q.pop_front();
    oh = 4'b0001 << e;
    vp = 4'b0101;
    chk("byte_len", byte_len, 64'(100 + e));
    ack = 1'b1;
    #1;
    chk("ack_onehot", rdy_for_fwd_ack, oh);
    tick();
    ack = 1'b0;
    rdy_for_fwd[e] = 1'b0;
    rd_en = 1'b1;
    addr = 8'd5;
    #1;
    chk("fwd_rd_en", fwd_rd_en, oh);
    chk("fwd_addr", fwd_addr, 5);
    chk("rd_data", rd_data, 64'hC0DE_0000_0000_0000 + 64'(e*16 + 3));
    chk("rd_data_vld", rd_data_vld, vp[e]);
    rd_en = 1'b0;
    done = 1'b1;
    #1;
    chk("fwd_done", fwd_done, oh);
    tick();
    done = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ordered = 1'b0; sn_grant_vld = 1'b0; sn_grant_tag = '0;
    core_rej = '0; rdy_for_fwd = '0; addr = '0; rd_en = 1'b0; done = 1'b0; ack = 1'b0;
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_seq_ovf", seq_ovf, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_fwd_rd_en", fwd_rd_en, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // round-robin: move rr_ptr to 2 via core 1, then cores 1 and 3 ready -> 3 then 1
    rdy_for_fwd = 4'b0010; exp_q.push_back(1);
    fwd_pkt();
    rdy_for_fwd = 4'b1010; exp_q.push_back(3); exp_q.push_back(1);
    fwd_pkt();
    fwd_pkt();
    chk("rr_pkt_cnt", pkt_cnt, 3);

    // in-order: grants 2,0,1, core 0 ready first must not be offered
    ordered = 1'b1;
    grant(2); grant(0); grant(1);
    exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1);
    rdy_for_fwd[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("inord_wait", rdy, 0);
    end
    rdy_for_fwd[2] = 1'b1; rdy_for_fwd[1] = 1'b1;
    fwd_pkt(); fwd_pkt(); fwd_pkt();
    chk("inord_pkt_cnt", pkt_cnt, 6);
    chk("inord_drop_cnt", drop_cnt, 0);

    // in-order skip of a rejected head
    grant(1); grant(3);
    core_rej = 4'b0010;
    tick();
    core_rej = '0;
    rdy_for_fwd[3] = 1'b1; exp_q.push_back(3);
    fwd_pkt();
    chk("skip_drop_cnt", drop_cnt, 1);
    chk("skip_pkt_cnt", pkt_cnt, 7);

    // fill, push+pop while full, then a true overflow
    grant(0); grant(1); grant(2); grant(3);
    chk("full_no_ovf", seq_ovf, 0);
    sn_grant_vld = 1'b1; sn_grant_tag = 2'd2; core_rej = 4'b0001;
    tick();
    sn_grant_vld = 1'b0; core_rej = '0;
    chk("pushpop_no_ovf", seq_ovf, 0);
    chk("pushpop_drop_cnt", drop_cnt, 2);
    grant(0);
    chk("ovf_set", seq_ovf, 1);
    rdy_for_fwd = 4'b1110;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    fwd_pkt(); fwd_pkt(); fwd_pkt();
    rdy_for_fwd[2] = 1'b1; exp_q.push_back(2);
    fwd_pkt();
    rdy_for_fwd[0] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("ovf_grant_discarded", rdy, 0);
    ordered = 1'b0; exp_q.push_back(0);
    fwd_pkt();
    chk("ovf_pkt_cnt", pkt_cnt, 12);

    // reset asserted in the middle of BUSY
    grant(1);
    rdy_for_fwd[1] = 1'b1;
    wait_rdy();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rd_en = 1'b1; done = 1'b1; ack = 1'b1;
    #1;
    chk("busy_rd_en", fwd_rd_en, 4'b0010);
    rst = 1'b0;
    #1;
    chk("arst_rdy", rdy, 0);
    chk("arst_fwd_rd_en", fwd_rd_en, 0);
    chk("arst_fwd_done", fwd_done, 0);
    chk("arst_ack", rdy_for_fwd_ack, 0);
    chk("arst_pkt_cnt", pkt_cnt, 0);
    chk("arst_drop_cnt", drop_cnt, 0);
    chk("arst_seq_ovf", seq_ovf, 0);
    chk("arst_rd_data", rd_data, 0);
    rd_en = 1'b0; done = 1'b0; ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
    ordered = 1'b1; rdy_for_fwd = 4'b0010;
    for (int i = 0; i < 4; i++) tick();
    chk("fifo_empty_after_rst", rdy, 0);
    grant(1); exp_q.push_back(1);
    fwd_pkt();
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
